// File: rtl/ifetch_pkg.sv
// ifetch_pkg: fetch FSM state encoding and branch-select codes shared by the fetch unit and the decoder.
package ifetch_pkg;
  localparam int INST_W = 17;
  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, ISSUE = 2'd2, DRAIN = 2'd3} state_t;
  localparam logic [1:0] BS_SEQ = 2'b00;
  localparam logic [1:0] BS_CBR = 2'b01;
  localparam logic [1:0] BS_JMP = 2'b10;
  localparam logic [1:0] BS_REL = 2'b11;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory, decoder-handshake and redirect signals of the fetch unit.
interface inst_fetch_if #(parameter int PC_W = 8, parameter int OFF_W = 9);
  import ifetch_pkg::*;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              imem_rvalid;
  logic [INST_W-1:0] inst_out;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              redir_valid;
  logic [PC_W-1:0]   br_pc;
  logic [1:0]        BS;
  logic              PS;
  logic              Z;
  logic [OFF_W-1:0]  br_off;
  logic [PC_W-1:0]   bus_a;
  modport master (
    output imem_req, imem_addr, inst_out, inst_pc, inst_valid,
    input  imem_rdata, imem_rvalid, inst_ready, redir_valid, br_pc, BS, PS, Z, br_off, bus_a
  );
  modport slave (
    input  imem_req, imem_addr, inst_out, inst_pc, inst_valid,
    output imem_rdata, imem_rvalid, inst_ready, redir_valid, br_pc, BS, PS, Z, br_off, bus_a
  );
endinterface

// File: rtl/pc_target_calc.sv
// pc_target_calc: resolves whether a branch is taken and where it goes (offsets are relative to br_pc+1).
module pc_target_calc import ifetch_pkg::*; #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 9
) (
  input  logic [PC_W-1:0]  br_pc,
  input  logic [1:0]       bs,
  input  logic             ps,
  input  logic             z,
  input  logic [OFF_W-1:0] br_off,
  input  logic [PC_W-1:0]  bus_a,
  output logic             taken,
  output logic [PC_W-1:0]  target
);
  logic [PC_W-1:0] seq;
  always_comb begin
    seq    = br_pc + 1'b1;
    taken  = bs == BS_SEQ ? 1'b0 : bs == BS_CBR ? z ^ ps : 1'b1;
    target = bs == BS_JMP ? bus_a : seq + PC_W'($signed(br_off));
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner; fetches one word at a time, hands it to the decoder, flushes on taken redirects.
// Optional IFETCH_PERF_CNT_EN adds saturating perf_fetch / perf_flush counters.
module inst_fetch import ifetch_pkg::*; #(
  parameter int              PC_W     = 8,
  parameter int              OFF_W    = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  inst_fetch_if.master bus
`ifdef IFETCH_PERF_CNT_EN
  , output logic [15:0] perf_fetch
  , output logic [15:0] perf_flush
`endif
);
  state_t          state, nxt;
  logic [PC_W-1:0] pc, target;
  logic            taken, redir, go, resp;
  pc_target_calc #(.PC_W(PC_W), .OFF_W(OFF_W)) u_calc (
    .br_pc(bus.br_pc), .bs(bus.BS), .ps(bus.PS), .z(bus.Z),
    .br_off(bus.br_off), .bus_a(bus.bus_a), .taken(taken), .target(target)
  );
  assign redir = bus.redir_valid && taken;
  assign resp  = state == WAIT && bus.imem_rvalid;
  // go holds off the first request until one clock after reset so imem_req stays low while in reset
  assign bus.imem_req  = state == FETCH && go;
  assign bus.imem_addr = bus.imem_req ? pc : '0;
  always_comb begin
    nxt = state;
    case (state)
      FETCH:   nxt = !go ? FETCH : redir ? DRAIN : WAIT;
      WAIT:    nxt = redir ? (bus.imem_rvalid ? FETCH : DRAIN) : bus.imem_rvalid ? ISSUE : WAIT;
      ISSUE:   nxt = redir || bus.inst_ready ? FETCH : ISSUE;
      DRAIN:   nxt = bus.imem_rvalid ? FETCH : DRAIN;
      default: nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FETCH;
      go             <= 1'b0;
      pc             <= RESET_PC;
      bus.inst_out   <= '0;
      bus.inst_pc    <= '0;
      bus.inst_valid <= 1'b0;
    end else begin
      state          <= nxt;
      go             <= 1'b1;
      pc             <= redir ? target : resp ? pc + 1'b1 : pc;
      bus.inst_valid <= nxt == ISSUE;
      if (resp && !redir) begin
        bus.inst_out <= bus.imem_rdata;
        bus.inst_pc  <= pc;
      end
    end
  end
`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch <= '0;
      perf_flush <= '0;
    end else begin
      perf_fetch <= perf_fetch + 16'(bus.imem_req && perf_fetch != 16'hFFFF);
      perf_flush <= perf_flush + 16'(redir && perf_flush != 16'hFFFF);
    end
  end
`endif
endmodule
